// File: rtl/alu_seq_if.sv
// Request/response channel of the sequential ALU: a valid/ready operation
// input and a valid/ready result output with flags.
interface alu_seq_if #(
    parameter int IN_WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_WIDTH-1:0]     a;
    logic [IN_WIDTH-1:0]     b;
    logic [2:0]              opcode;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*IN_WIDTH-1:0]   result;
    logic                    zero;
    logic                    div0;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero, div0
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero, div0
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle logic/add ops, iterative shift-add
// multiply and restoring divide, registered result with zero/div0 flags.
module alu_seq #(
    parameter int IN_WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int RW = 2 * IN_WIDTH;
    localparam int CW = $clog2(IN_WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [RW-1:0]        result_r;
    logic                 zero_r;
    logic                 div0_r;

    logic [2:0]           op_p0;
    logic [IN_WIDTH-1:0]  b_p0;
    logic [RW-1:0]        mcand_p0;
    logic [IN_WIDTH-1:0]  mplier_p0;
    logic [RW-1:0]        acc_p0;
    logic [IN_WIDTH-1:0]  rem_p0;
    logic [IN_WIDTH-1:0]  quot_p0;

    logic                 accept;
    logic                 iter_op;
    logic [RW-1:0]        imm_result;
    logic [RW-1:0]        acc_next;
    logic [IN_WIDTH:0]    rem_shift;
    logic [IN_WIDTH:0]    trial;
    logic [IN_WIDTH-1:0]  rem_next;
    logic [IN_WIDTH-1:0]  quot_next;
    logic [RW-1:0]        iter_result;

    // Single-cycle operations on zero-extended operands, modulo 2^RW.
    function automatic logic [RW-1:0] alu_logic(
        input logic [2:0]          op,
        input logic [IN_WIDTH-1:0] x,
        input logic [IN_WIDTH-1:0] y
    );
        logic [RW-1:0] xe;
        logic [RW-1:0] ye;
        logic [RW-1:0] r;
        xe = {{IN_WIDTH{1'b0}}, x};
        ye = {{IN_WIDTH{1'b0}}, y};
        case (op)
            OP_ADD:  r = xe + ye;
            OP_SUB:  r = xe - ye;
            OP_AND:  r = xe & ye;
            OP_OR:   r = xe | ye;
            OP_XOR:  r = xe ^ ye;
            OP_SHL:  r = (32'(y) >= 32'(RW)) ? '0 : (xe << y);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept     = (state == IDLE) && bus.in_valid;
    assign iter_op    = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
    assign imm_result = alu_logic(bus.opcode, bus.a, bus.b);

    // With b == 0 every trial subtraction succeeds, giving all-ones quotient and remainder = a.
    always_comb begin
        acc_next    = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
        rem_shift   = {rem_p0, quot_p0[IN_WIDTH-1]};
        trial       = rem_shift - {1'b0, b_p0};
        rem_next    = rem_shift[IN_WIDTH-1:0];
        quot_next   = {quot_p0[IN_WIDTH-2:0], 1'b0};
        if (!trial[IN_WIDTH]) begin
            rem_next  = trial[IN_WIDTH-1:0];
            quot_next = {quot_p0[IN_WIDTH-2:0], 1'b1};
        end
        iter_result = (op_p0 == OP_MUL) ? acc_next : {rem_next, quot_next};
    end

    // Stage p0: operand capture on accept, then one iteration step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0     <= bus.opcode;
            b_p0      <= bus.b;
            mcand_p0  <= {{IN_WIDTH{1'b0}}, bus.a};
            mplier_p0 <= bus.b;
            acc_p0    <= '0;
            rem_p0    <= '0;
            quot_p0   <= bus.a;
        end else if (state == BUSY) begin
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            acc_p0    <= acc_next;
            rem_p0    <= rem_next;
            quot_p0   <= quot_next;
        end
    end

    // Stage p1: control FSM and registered result/flags presented in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            div0_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        cnt        <= '0;
                        if (iter_op) begin
                            state <= BUSY;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= imm_result;
                            zero_r      <= (imm_result == '0);
                            div0_r      <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CW'(IN_WIDTH - 1)) begin
                        state       <= DONE;
                        cnt         <= '0;
                        out_valid_r <= 1'b1;
                        result_r    <= iter_result;
                        zero_r      <= (iter_result == '0);
                        div0_r      <= (op_p0 == OP_DIV) && (b_p0 == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.div0      = div0_r;
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, handshaked successor to the combinational `alu`. It accepts one operation at a time over a valid/ready input channel and executes it. Logic and add operations complete in one cycle; multiply and divide are iterative and take IN_WIDTH cycles. The registered result and flags are presented over a valid/ready output channel. The block sits between an operand source (sequencer or testbench driver) and a result consumer, and is parametrised in operand width.

## Interface
- IN_WIDTH, default 4: operand width in bits, must be ≥ 2. Result width is 2*IN_WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  IN_WIDTH  operand A, unsigned.
- b  input  IN_WIDTH  operand B, unsigned.
- opcode  input  3  operation select, see Operation.
- out_valid  output  1  result, zero and div0 are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  2*IN_WIDTH  registered result.
- zero  output  1  result == 0.
- div0  output  1  last operation was DIV with b == 0.

## Operation
- Operands are zero-extended to 2*IN_WIDTH. Arithmetic is modulo 2^(2*IN_WIDTH).
- Opcodes:
  - 0 ADD: a+b. Carry lands in bit IN_WIDTH.
  - 1 SUB: a−b, two's complement at 2*IN_WIDTH.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 MUL: a*b, shift-add, one partial product per cycle.
  - 6 DIV: restoring division, one quotient bit per cycle. result = {remainder, quotient}, each IN_WIDTH bits.
  - 7 SHL: zero-extended a shifted left by b. Shift amounts ≥ 2*IN_WIDTH give 0.
- a, b and opcode are captured into internal registers on acceptance. Input changes after acceptance have no effect.
- DIV with b == 0 runs the normal iteration and yields quotient = all ones, remainder = a, with div0 = 1. div0 = 0 for every other operation.
- zero and div0 are registered together with result and change only when the block enters DONE.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, go to BUSY if opcode is 5 or 6, otherwise go to DONE with the result computed.
  - BUSY: iteration counter runs from 0 to IN_WIDTH−1. After the last step, go to DONE with result written.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- At most one operation is in flight. No request is accepted in BUSY or DONE.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, div0 = 0, counter = 0.
- Latency, counted from the accept edge (in_valid & in_ready) to the first cycle with out_valid = 1:
  - ADD, SUB, AND, OR, XOR, SHL: 1 cycle.
  - MUL, DIV: IN_WIDTH+1 cycles.
- Output handshake completes on an edge where out_valid & out_ready. in_ready rises in the following cycle. Minimum spacing between accepts is 2 cycles for single-cycle ops and IN_WIDTH+2 cycles for MUL/DIV.
- Backpressure: while out_ready = 0, result, zero, div0 and out_valid are held stable indefinitely.
- out_ready high outside DONE has no effect. in_valid outside IDLE is ignored and not queued.
- rst asserted in any state, including mid-iteration in BUSY: the operation is aborted and all registers take their reset values on that edge. No partial result is ever presented. rst has priority over every handshake in the same cycle.
- Results are identical for every IN_WIDTH ≥ 2. The iteration counter width is $clog2(IN_WIDTH)+1.

## Test plan
- IN_WIDTH=4, ADD a=15 b=15 -> result=0x1E, zero=0. out_valid one cycle after accept.
- SUB a=3 b=5 -> result=0xFE. SUB a=7 b=7 -> result=0x00, zero=1.
- MUL a=15 b=15 -> result=0xE1 (225) exactly 5 cycles after accept, with in_ready=0 throughout. DIV a=13 b=4 -> result=0x13 (rem 1, quot 3), div0=0.
- DIV a=9 b=0 -> result=0x9F, div0=1, latency 5. The following AND a=12 b=10 -> result=0x08, div0=0.
- Backpressure: ADD a=1 b=2 with out_ready held low for 3 cycles -> result=0x03 and out_valid stable for all 3 cycles, in_ready=0. A new request offered during that time is not accepted.
- Reset mid-MUL: assert rst in the 2nd BUSY cycle -> next cycle out_valid=0, result=0, in_ready=1. A fresh SHL a=1 b=7 then yields 0x80.
